// File: rtl/ncl_seq_pkg.sv
// rtl/ncl_seq_pkg.sv - dual-rail encodings and FSM state types for the NCL counter sequencer
package ncl_seq_pkg;

  localparam logic [1:0] NULL    = 2'b00;
  localparam logic [1:0] DATA0   = 2'b01;
  localparam logic [1:0] DATA1   = 2'b10;
  localparam logic [1:0] ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    I_IDLE,
    I_DATA,
    I_NULL,
    I_HOLD
  } inj_state_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_NULL
  } snk_state_e;

endpackage

// File: rtl/ncl_sync2.sv
// rtl/ncl_sync2.sv - parameterized-width two-flop synchronizer with synchronous active-high init
module ncl_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         init,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (init) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ncl_counter_sequencer.sv
// rtl/ncl_counter_sequencer.sv - injects increment wavefronts into an NCL counter chain and sinks its sum wavefronts
module ncl_counter_sequencer
  import ncl_seq_pkg::*;
#(
  parameter int NDIG        = 32,
  parameter int NINC_W      = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              init,
  input  logic              start,
  input  logic [NINC_W-1:0] num_incr,
  output logic [1:0]        carryin_rail,
  input  logic              carryin_comp,
  input  logic [2*NDIG-1:0] sum_rail,
  output logic              sum_comp,
  input  logic [1:0]        carryout_rail,
  output logic              carryout_comp,
  output logic [NDIG-1:0]   count_value,
  output logic              value_valid,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              err_illegal,
  output logic              err_timeout
);

  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  logic [2*NDIG-1:0] sum_s;
  logic [1:0]        co_s;
  logic              cin_s;

  ncl_sync2 #(.W(2*NDIG)) u_sync_sum (
    .clk  (clk),
    .init (init),
    .d_i  (sum_rail),
    .q_o  (sum_s)
  );

  ncl_sync2 #(.W(2)) u_sync_cout (
    .clk  (clk),
    .init (init),
    .d_i  (carryout_rail),
    .q_o  (co_s)
  );

  ncl_sync2 #(.W(1)) u_sync_cin (
    .clk  (clk),
    .init (init),
    .d_i  (carryin_comp),
    .q_o  (cin_s)
  );

  inj_state_e        inj_q;
  snk_state_e        snk_q;
  logic [NINC_W-1:0] inj_left_q;
  logic [NINC_W-1:0] run_len_q;
  logic [NINC_W-1:0] snk_cnt_q;
  logic [WD_W-1:0]   wd_q;
  logic [1:0]        carryin_rail_q;
  logic              sum_comp_q;
  logic              carryout_comp_q;
  logic [NDIG-1:0]   count_value_q;
  logic              value_valid_q;
  logic              busy_q;
  logic              done_q;
  logic              overflow_q;
  logic              err_illegal_q;
  logic              err_timeout_q;

  // A wavefront is complete once no pair is NULL; an 11 pair still completes so it can be flagged.
  logic            all_valid;
  logic            all_null;
  logic            any_illegal;
  logic [NDIG-1:0] cap_val;

  always_comb begin
    all_valid   = (co_s != NULL);
    all_null    = (co_s == NULL);
    any_illegal = (co_s == ILLEGAL);
    cap_val     = '0;
    for (int k = 0; k < NDIG; k++) begin
      all_valid   = all_valid & (sum_s[2*k +: 2] != NULL);
      all_null    = all_null & (sum_s[2*k +: 2] == NULL);
      any_illegal = any_illegal | (sum_s[2*k +: 2] == ILLEGAL);
      cap_val[k]  = sum_s[2*k + 1];
    end
  end

  logic progress;
  logic run_end;

  assign progress = ((inj_q == I_DATA) && cin_s) ||
                    ((inj_q == I_NULL) && !cin_s) ||
                    ((snk_q == S_DATA) && all_valid) ||
                    ((snk_q == S_NULL) && all_null);

  assign run_end = (inj_q == I_HOLD) && (snk_cnt_q == run_len_q);

  always_ff @(posedge clk) begin
    if (init) begin
      inj_q           <= I_IDLE;
      snk_q           <= S_IDLE;
      inj_left_q      <= '0;
      run_len_q       <= '0;
      snk_cnt_q       <= '0;
      wd_q            <= '0;
      carryin_rail_q  <= NULL;
      sum_comp_q      <= 1'b0;
      carryout_comp_q <= 1'b0;
      count_value_q   <= '0;
      value_valid_q   <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      overflow_q      <= 1'b0;
      err_illegal_q   <= 1'b0;
      err_timeout_q   <= 1'b0;
    end else begin
      value_valid_q <= 1'b0;
      done_q        <= 1'b0;

      if (busy_q && !progress && (wd_q == WD_LAST)) begin
        // Stalled chain: release it by presenting NULL and dropping both completions.
        err_timeout_q   <= 1'b1;
        inj_q           <= I_IDLE;
        snk_q           <= S_IDLE;
        busy_q          <= 1'b0;
        wd_q            <= '0;
        carryin_rail_q  <= NULL;
        sum_comp_q      <= 1'b0;
        carryout_comp_q <= 1'b0;
      end else if (busy_q && run_end) begin
        done_q          <= 1'b1;
        inj_q           <= I_IDLE;
        snk_q           <= S_IDLE;
        busy_q          <= 1'b0;
        wd_q            <= '0;
        carryin_rail_q  <= NULL;
        sum_comp_q      <= 1'b0;
        carryout_comp_q <= 1'b0;
      end else begin
        wd_q <= (progress || !busy_q) ? '0 : wd_q + 1'b1;

        // Injector and sink advance independently; coupling them deadlocks the chain.
        case (inj_q)
          I_IDLE: begin
            if (start && !busy_q) begin
              if (num_incr == '0) begin
                done_q <= 1'b1;
              end else begin
                inj_left_q     <= num_incr;
                run_len_q      <= num_incr;
                snk_cnt_q      <= '0;
                busy_q         <= 1'b1;
                inj_q          <= I_DATA;
                snk_q          <= S_DATA;
                carryin_rail_q <= DATA1;
              end
            end
          end
          I_DATA: begin
            if (cin_s) begin
              inj_left_q     <= inj_left_q - 1'b1;
              inj_q          <= I_NULL;
              carryin_rail_q <= NULL;
            end
          end
          I_NULL: begin
            if (!cin_s) begin
              if (inj_left_q != '0) begin
                inj_q          <= I_DATA;
                carryin_rail_q <= DATA1;
              end else begin
                inj_q <= I_HOLD;
              end
            end
          end
          I_HOLD: begin
            carryin_rail_q <= NULL;
          end
          default: inj_q <= I_IDLE;
        endcase

        case (snk_q)
          S_IDLE: ;
          S_DATA: begin
            if (all_valid) begin
              count_value_q   <= cap_val;
              value_valid_q   <= 1'b1;
              if (co_s == DATA1) overflow_q <= 1'b1;
              if (any_illegal) err_illegal_q <= 1'b1;
              sum_comp_q      <= 1'b1;
              carryout_comp_q <= 1'b1;
              snk_q           <= S_NULL;
            end
          end
          S_NULL: begin
            if (all_null) begin
              sum_comp_q      <= 1'b0;
              carryout_comp_q <= 1'b0;
              snk_cnt_q       <= snk_cnt_q + 1'b1;
              snk_q           <= S_DATA;
            end
          end
          default: snk_q <= S_IDLE;
        endcase
      end
    end
  end

  assign carryin_rail  = carryin_rail_q;
  assign sum_comp      = sum_comp_q;
  assign carryout_comp = carryout_comp_q;
  assign count_value   = count_value_q;
  assign value_valid   = value_valid_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign overflow      = overflow_q;
  assign err_illegal   = err_illegal_q;
  assign err_timeout   = err_timeout_q;

endmodule

// File: tb/tb_ncl_counter_sequencer.sv
// tb/tb_ncl_counter_sequencer.sv - directed bench with a behavioural 4-digit NCL counter chain model
module tb_ncl_counter_sequencer;

  localparam int NDIG = 4;
  localparam int NW   = 8;
  localparam int TO   = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              init;
  logic              start;
  logic [NW-1:0]     num_incr;
  logic [1:0]        carryin_rail;
  logic              carryin_comp;
  logic [2*NDIG-1:0] sum_rail;
  logic              sum_comp;
  logic [1:0]        carryout_rail;
  logic              carryout_comp;
  logic [NDIG-1:0]   count_value;
  logic              value_valid;
  logic              busy;
  logic              done;
  logic              overflow;
  logic              err_illegal;
  logic              err_timeout;

  ncl_counter_sequencer #(
    .NDIG        (NDIG),
    .NINC_W      (NW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk           (clk),
    .init          (init),
    .start         (start),
    .num_incr      (num_incr),
    .carryin_rail  (carryin_rail),
    .carryin_comp  (carryin_comp),
    .sum_rail      (sum_rail),
    .sum_comp      (sum_comp),
    .carryout_rail (carryout_rail),
    .carryout_comp (carryout_comp),
    .count_value   (count_value),
    .value_valid   (value_valid),
    .busy          (busy),
    .done          (done),
    .overflow      (overflow),
    .err_illegal   (err_illegal),
    .err_timeout   (err_timeout)
  );

  // Chain model: digit 0 acks each DATA1/NULL injection, digits emit value+1 once the sink is free.
  logic            m_load     = 1'b1;
  logic            m_withhold = 1'b0;
  logic [NDIG-1:0] m_preload  = '0;
  logic [7:0]      m_bad_wave = '0;
  logic [NDIG-1:0] mcnt;
  logic            m_data;
  logic [7:0]      m_pend;
  logic [7:0]      m_wave;
  logic            m_inc;
  logic            m_dec;

  assign m_inc = (carryin_rail == 2'b10) && !carryin_comp && !m_withhold && !m_load;
  assign m_dec = !m_data && !sum_comp && (m_pend != 8'd0) && !m_load;

  function automatic logic [2*NDIG-1:0] enc(input logic [NDIG-1:0] v, input logic bad);
    logic [2*NDIG-1:0] r;
    for (int k = 0; k < NDIG; k++) r[2*k +: 2] = v[k] ? 2'b10 : 2'b01;
    if (bad) r[5:4] = 2'b11;
    return r;
  endfunction

  always @(negedge clk) begin
    if (m_load) begin
      mcnt          <= m_preload;
      m_data        <= 1'b0;
      m_pend        <= 8'd0;
      m_wave        <= 8'd0;
      sum_rail      <= '0;
      carryout_rail <= 2'b00;
      carryin_comp  <= 1'b0;
    end else begin
      if (m_inc) carryin_comp <= 1'b1;
      else if ((carryin_rail == 2'b00) && carryin_comp) carryin_comp <= 1'b0;
      m_pend <= m_pend + {7'd0, m_inc} - {7'd0, m_dec};
      if (m_dec) begin
        mcnt          <= mcnt + 1'b1;
        sum_rail      <= enc(mcnt + 1'b1, (m_wave + 8'd1) == m_bad_wave);
        carryout_rail <= (mcnt == {NDIG{1'b1}}) ? 2'b10 : 2'b01;
        m_wave        <= m_wave + 8'd1;
        m_data        <= 1'b1;
      end else if (m_data && sum_comp && carryout_comp) begin
        sum_rail      <= '0;
        carryout_rail <= 2'b00;
        m_data        <= 1'b0;
      end
    end
  end

  int              n_vv   = 0;
  int              n_done = 0;
  int              n_cin  = 0;
  logic [NDIG-1:0] vv_val[$];
  logic            vv_ov[$];
  logic [1:0]      cin_prev = 2'b00;

  always @(negedge clk) begin
    cin_prev <= carryin_rail;
    if (value_valid) begin
      vv_val.push_back(count_value);
      vv_ov.push_back(overflow);
      n_vv <= n_vv + 1;
    end
    if (done) n_done <= n_done + 1;
    if ((carryin_rail == 2'b10) && (cin_prev != 2'b10)) n_cin <= n_cin + 1;
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_init();
    @(negedge clk);
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
  endtask

  task automatic load_model(input logic [NDIG-1:0] v, input logic [7:0] bad, input logic hold);
    @(posedge clk);
    m_preload  = v;
    m_bad_wave = bad;
    m_withhold = hold;
    m_load     = 1'b1;
    @(posedge clk);
    m_load     = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic run_incr(input int n, input int restart_at, input int budget);
    @(negedge clk);
    start    = 1'b1;
    num_incr = NW'(n);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < budget && busy; i++) begin
      if (i == restart_at) begin
        start    = 1'b1;
        num_incr = NW'(1);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("run_ends", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  int base, d0, c0;

  initial begin
    init     = 1'b0;
    start    = 1'b0;
    num_incr = '0;
    load_model(4'd0, 8'd0, 1'b0);
    do_init();

    chk("rst_count", {28'd0, count_value}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_vv", {31'd0, value_valid}, 32'd0);
    chk("rst_cin", {30'd0, carryin_rail}, 32'd0);
    chk("rst_comps", {30'd0, sum_comp, carryout_comp}, 32'd0);
    chk("rst_sticky", {29'd0, overflow, err_illegal, err_timeout}, 32'd0);

    // single increment from 0
    base = vv_val.size(); d0 = n_done; c0 = n_cin;
    run_incr(1, -1, 300);
    chk("one_nvv", 32'(vv_val.size() - base), 32'd1);
    chk("one_val", {28'd0, vv_val[base]}, 32'd1);
    chk("one_done", 32'(n_done - d0), 32'd1);
    chk("one_cin", 32'(n_cin - c0), 32'd1);

    // five increments from 0, with a start pulse mid-run that must be ignored
    load_model(4'd0, 8'd0, 1'b0);
    base = vv_val.size(); d0 = n_done; c0 = n_cin;
    run_incr(5, 8, 600);
    chk("five_nvv", 32'(vv_val.size() - base), 32'd5);
    for (int i = 0; i < 5; i++)
      if (base + i < vv_val.size()) chk("five_val", {28'd0, vv_val[base + i]}, 32'(i + 1));
    chk("five_cin", 32'(n_cin - c0), 32'd5);
    chk("five_done", 32'(n_done - d0), 32'd1);
    chk("five_count", {28'd0, count_value}, 32'd5);

    // num_incr = 0 finishes on the next cycle without busy
    @(negedge clk);
    start    = 1'b1;
    num_incr = '0;
    @(negedge clk);
    start = 1'b0;
    chk("zero_done", {31'd0, done}, 32'd1);
    chk("zero_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("zero_done_pulse", {31'd0, done}, 32'd0);

    // wrap from 14: 15, 0, 1 with overflow from the second capture on
    load_model(4'd14, 8'd0, 1'b0);
    chk("wrap_ov_before", {31'd0, overflow}, 32'd0);
    base = vv_val.size();
    run_incr(3, -1, 400);
    chk("wrap_nvv", 32'(vv_val.size() - base), 32'd3);
    if (vv_val.size() >= base + 3) begin
      chk("wrap_v0", {28'd0, vv_val[base]}, 32'd15);
      chk("wrap_v1", {28'd0, vv_val[base + 1]}, 32'd0);
      chk("wrap_v2", {28'd0, vv_val[base + 2]}, 32'd1);
      chk("wrap_ov0", {31'd0, vv_ov[base]}, 32'd0);
      chk("wrap_ov1", {31'd0, vv_ov[base + 1]}, 32'd1);
      chk("wrap_ov2", {31'd0, vv_ov[base + 2]}, 32'd1);
    end
    chk("wrap_ov_sticky", {31'd0, overflow}, 32'd1);

    // digit 2 reads 11 on the second wavefront: value 2 captured as 6
    do_init();
    chk("init_clears_ov", {31'd0, overflow}, 32'd0);
    load_model(4'd0, 8'd2, 1'b0);
    base = vv_val.size(); d0 = n_done;
    run_incr(3, -1, 400);
    chk("ill_nvv", 32'(vv_val.size() - base), 32'd3);
    if (vv_val.size() >= base + 3) begin
      chk("ill_v0", {28'd0, vv_val[base]}, 32'd1);
      chk("ill_v1", {28'd0, vv_val[base + 1]}, 32'd6);
      chk("ill_v2", {28'd0, vv_val[base + 2]}, 32'd3);
    end
    chk("ill_flag", {31'd0, err_illegal}, 32'd1);
    chk("ill_done", 32'(n_done - d0), 32'd1);

    // digit 0 never acknowledges: watchdog fires
    do_init();
    load_model(4'd0, 8'd0, 1'b1);
    d0 = n_done;
    @(negedge clk);
    start    = 1'b1;
    num_incr = NW'(2);
    @(negedge clk);
    start = 1'b0;
    chk("to_busy_up", {31'd0, busy}, 32'd1);
    for (int i = 0; i < TO + 2 && !err_timeout; i++) @(negedge clk);
    chk("to_flag", {31'd0, err_timeout}, 32'd1);
    chk("to_busy", {31'd0, busy}, 32'd0);
    chk("to_cin", {30'd0, carryin_rail}, 32'd0);
    chk("to_comps", {30'd0, sum_comp, carryout_comp}, 32'd0);
    repeat (3) @(negedge clk);
    chk("to_no_done", 32'(n_done - d0), 32'd0);

    // init mid-run while sum_comp is asserted, then a clean run
    do_init();
    load_model(4'd0, 8'd0, 1'b0);
    @(negedge clk);
    start    = 1'b1;
    num_incr = NW'(3);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 200 && !sum_comp; i++) @(negedge clk);
    chk("mid_scomp", {31'd0, sum_comp}, 32'd1);
    do_init();
    chk("mid_busy", {31'd0, busy}, 32'd0);
    chk("mid_comps", {30'd0, sum_comp, carryout_comp}, 32'd0);
    chk("mid_cin", {30'd0, carryin_rail}, 32'd0);
    chk("mid_count", {28'd0, count_value}, 32'd0);
    chk("mid_pulses", {30'd0, value_valid, done}, 32'd0);
    chk("mid_sticky", {29'd0, overflow, err_illegal, err_timeout}, 32'd0);
    load_model(4'd0, 8'd0, 1'b0);
    base = vv_val.size(); d0 = n_done;
    run_incr(2, -1, 300);
    chk("after_nvv", 32'(vv_val.size() - base), 32'd2);
    if (vv_val.size() >= base + 2) begin
      chk("after_v0", {28'd0, vv_val[base]}, 32'd1);
      chk("after_v1", {28'd0, vv_val[base + 1]}, 32'd2);
    end
    chk("after_done", 32'(n_done - d0), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
